// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: arbitrates trap sources, flushes, saves EPC/Cause/Status, vectors; also sequences ERET.
// Optional macro CP0_INT_EN enables external interrupt qualification; when undefined int_pend is ignored.
module cp0_exc_ctrl #(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0180,
  parameter logic [7:0]  EPC_IDX     = 8'd112,
  parameter logic [7:0]  CAUSE_IDX   = 8'd104,
  parameter logic [7:0]  STATUS_IDX  = 8'd96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exc_pc,
  input  logic        req_ov,
  input  logic        req_sys,
  input  logic        req_brk,
  input  logic        req_ri,
  input  logic [5:0]  int_pend,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [7:0]  mtc0_idx,
  input  logic [31:0] mtc0_data,
  output logic        stall,
  output logic        flush,
  output logic        cp0_we,
  output logic [7:0]  cp0_idx,
  output logic [31:0] cp0_wdata,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, FLUSH, SAV_EPC, SAV_CAUSE, SAV_STAT, VECTOR, ERET_CLR, ERET_JMP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] status_sh_q, status_sh_d;
  logic [31:0] epc_sh_q, epc_sh_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  code_q, code_d;

  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic        cp0_we_q, cp0_we_d;
  logic [7:0]  cp0_idx_q, cp0_idx_d;
  logic [31:0] cp0_wdata_q, cp0_wdata_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        busy_q, busy_d;

  logic        int_take;
  logic [5:0]  ip_bits;
  logic        exc_any;

`ifdef CP0_INT_EN
  assign int_take = (|(int_pend & status_sh_q[15:10])) & status_sh_q[0] & ~status_sh_q[1];
  assign ip_bits  = int_pend;
`else
  assign int_take = 1'b0;
  assign ip_bits  = int_pend & 6'h00;
`endif

  assign exc_any = int_take | req_ov | req_sys | req_brk | req_ri;

  always_comb begin
    state_d       = state_q;
    status_sh_d   = status_sh_q;
    epc_sh_d      = epc_sh_q;
    pc_d          = pc_q;
    code_d        = code_q;
    cp0_we_d      = 1'b0;
    cp0_idx_d     = 8'h00;
    cp0_wdata_d   = 32'h0;
    flush_d       = 1'b0;
    redir_valid_d = 1'b0;
    redir_pc_d    = 32'h0;

    // Next-state selection; shadows follow MTC0 only while idle.
    case (state_q)
      IDLE: begin
        if (mtc0_we && (mtc0_idx == STATUS_IDX)) status_sh_d = mtc0_data;
        if (mtc0_we && (mtc0_idx == EPC_IDX))    epc_sh_d    = mtc0_data;
        if (exc_any) begin
          state_d = FLUSH;
          pc_d    = exc_pc;
          if (int_take)     code_d = 5'h00;
          else if (req_ov)  code_d = 5'h0C;
          else if (req_sys) code_d = 5'h08;
          else if (req_brk) code_d = 5'h09;
          else              code_d = 5'h0A;
        end else if (eret) begin
          state_d = ERET_CLR;
        end
      end
      FLUSH:     state_d = status_sh_q[1] ? SAV_CAUSE : SAV_EPC;
      SAV_EPC:   state_d = SAV_CAUSE;
      SAV_CAUSE: state_d = SAV_STAT;
      SAV_STAT:  state_d = VECTOR;
      VECTOR:    state_d = IDLE;
      ERET_CLR:  state_d = ERET_JMP;
      ERET_JMP:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register with it.
    case (state_d)
      FLUSH: flush_d = 1'b1;
      SAV_EPC: begin
        cp0_we_d    = 1'b1;
        cp0_idx_d   = EPC_IDX;
        cp0_wdata_d = pc_q;
        epc_sh_d    = pc_q;
      end
      SAV_CAUSE: begin
        cp0_we_d    = 1'b1;
        cp0_idx_d   = CAUSE_IDX;
        cp0_wdata_d = {16'h0, ip_bits, 3'b000, code_q, 2'b00};
      end
      SAV_STAT: begin
        cp0_we_d    = 1'b1;
        cp0_idx_d   = STATUS_IDX;
        cp0_wdata_d = status_sh_q | 32'h0000_0002;
        status_sh_d = status_sh_q | 32'h0000_0002;
      end
      VECTOR: begin
        redir_valid_d = 1'b1;
        redir_pc_d    = VECTOR_ADDR;
      end
      ERET_CLR: begin
        flush_d     = 1'b1;
        cp0_we_d    = 1'b1;
        cp0_idx_d   = STATUS_IDX;
        cp0_wdata_d = status_sh_d & ~32'h0000_0002;
        status_sh_d = status_sh_d & ~32'h0000_0002;
      end
      ERET_JMP: begin
        redir_valid_d = 1'b1;
        redir_pc_d    = epc_sh_q;
      end
      default: ;
    endcase

    stall_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      status_sh_q   <= 32'h0;
      epc_sh_q      <= 32'h0;
      pc_q          <= 32'h0;
      code_q        <= 5'h0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      cp0_we_q      <= 1'b0;
      cp0_idx_q     <= 8'h0;
      cp0_wdata_q   <= 32'h0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'h0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      status_sh_q   <= status_sh_d;
      epc_sh_q      <= epc_sh_d;
      pc_q          <= pc_d;
      code_q        <= code_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
      cp0_we_q      <= cp0_we_d;
      cp0_idx_q     <= cp0_idx_d;
      cp0_wdata_q   <= cp0_wdata_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      busy_q        <= busy_d;
    end
  end

  assign stall       = stall_q;
  assign flush       = flush_q;
  assign cp0_we      = cp0_we_q;
  assign cp0_idx     = cp0_idx_q;
  assign cp0_wdata   = cp0_wdata_q;
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: expected flush/CP0-write/redirect events, tagged with their cycle, are queued at stimulus time.
module tb_cp0_exc_ctrl;

  localparam logic [7:0] EPC_I  = 8'd112;
  localparam logic [7:0] CAUSE_I = 8'd104;
  localparam logic [7:0] STAT_I = 8'd96;
`ifdef CP0_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exc_pc;
  logic        req_ov, req_sys, req_brk, req_ri, eret, mtc0_we;
  logic [5:0]  int_pend;
  logic [7:0]  mtc0_idx;
  logic [31:0] mtc0_data;
  logic        stall, flush, cp0_we, redir_valid, busy;
  logic [7:0]  cp0_idx;
  logic [31:0] cp0_wdata, redir_pc;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [63:0] sb[$];
  logic [31:0] st_m = 32'h0;
  logic [31:0] epc_m = 32'h0;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .exc_pc(exc_pc),
    .req_ov(req_ov), .req_sys(req_sys), .req_brk(req_brk), .req_ri(req_ri),
    .int_pend(int_pend), .eret(eret),
    .mtc0_we(mtc0_we), .mtc0_idx(mtc0_idx), .mtc0_data(mtc0_data),
    .stall(stall), .flush(flush), .cp0_we(cp0_we), .cp0_idx(cp0_idx),
    .cp0_wdata(cp0_wdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event word: {kind, cycle, idx, data}; kind 1=flush, 2=CP0 write, 3=redirect.
  function automatic logic [63:0] ev(input logic [3:0] kind, input int c, input logic [7:0] idx,
                                     input logic [31:0] d);
    logic [19:0] c20;
    c20 = c[19:0];
    return {kind, c20, idx, d};
  endfunction

  task automatic sb_check(input string tag, input logic [63:0] got);
    logic [63:0] exp;
    if (sb.size() == 0) check({tag, "_spurious"}, got, '1);
    else begin
      exp = sb.pop_front();
      check(tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (flush)       sb_check("flush", ev(4'd1, cyc, 8'h0, 32'h0));
    if (cp0_we)      sb_check("cp0_wr", ev(4'd2, cyc, cp0_idx, cp0_wdata));
    if (redir_valid) sb_check("redir", ev(4'd3, cyc, 8'h0, redir_pc));
    if (!cp0_we)     check("wport_idle_zero", {24'h0, cp0_idx, cp0_wdata}, 64'h0);
  end

  // Reference model of one request cycle; k is the cycle count when the request is presented.
  task automatic model(input logic ov, sys, brk, ri, er, input logic [5:0] ip,
                       input logic [31:0] pc, input int k, output logic bz);
    logic       it;
    logic [4:0] code;
    logic [5:0] ipc;
    int         t;
    it  = INT_EN && (|(ip & st_m[15:10])) && st_m[0] && !st_m[1];
    ipc = INT_EN ? ip : 6'd0;
    bz  = 1'b1;
    if (it || ov || sys || brk || ri) begin
      code = it ? 5'h00 : ov ? 5'h0C : sys ? 5'h08 : brk ? 5'h09 : 5'h0A;
      sb.push_back(ev(4'd1, k + 1, 8'h0, 32'h0));
      t = k + 2;
      if (!st_m[1]) begin
        sb.push_back(ev(4'd2, t, EPC_I, pc));
        epc_m = pc;
        t++;
      end
      sb.push_back(ev(4'd2, t, CAUSE_I, {16'h0, ipc, 3'b000, code, 2'b00}));
      t++;
      st_m = st_m | 32'h2;
      sb.push_back(ev(4'd2, t, STAT_I, st_m));
      t++;
      sb.push_back(ev(4'd3, t, 8'h0, 32'h0000_0180));
    end else if (er) begin
      st_m = st_m & ~32'h2;
      sb.push_back(ev(4'd1, k + 1, 8'h0, 32'h0));
      sb.push_back(ev(4'd2, k + 1, STAT_I, st_m));
      sb.push_back(ev(4'd3, k + 2, 8'h0, epc_m));
    end else begin
      bz = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("idle_timeout", {63'h0, busy}, 64'h0);
  endtask

  task automatic req(input logic ov, sys, brk, ri, er, input logic [5:0] ip, input logic [31:0] pc);
    logic bz;
    @(negedge clk);
    req_ov = ov; req_sys = sys; req_brk = brk; req_ri = ri; eret = er;
    int_pend = ip; exc_pc = pc;
    model(ov, sys, brk, ri, er, ip, pc, cyc, bz);
    @(negedge clk);
    req_ov = 0; req_sys = 0; req_brk = 0; req_ri = 0; eret = 0; exc_pc = 32'h0;
    check("busy_after_req", {62'h0, stall, busy}, {62'h0, bz, bz});
    wait_idle();
    int_pend = 6'h0;
  endtask

  task automatic do_eret();
    logic bz;
    @(negedge clk);
    eret = 1'b1;
    model(0, 0, 0, 0, 1, 6'h0, 32'h0, cyc, bz);
    @(negedge clk);
    eret = 1'b0;
    check("eret_busy_c1", {63'h0, busy}, {63'h0, bz});
    @(negedge clk);
    check("eret_busy_c2", {63'h0, busy}, {63'h0, bz});
    @(negedge clk);
    check("eret_busy_c3", {63'h0, busy}, 64'h0);
  endtask

  task automatic mtc0(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    mtc0_we = 1'b1; mtc0_idx = idx; mtc0_data = d;
    if (idx == STAT_I) st_m = d;
    if (idx == EPC_I)  epc_m = d;
    @(negedge clk);
    mtc0_we = 1'b0; mtc0_idx = 8'h0; mtc0_data = 32'h0;
  endtask

  initial begin
    logic bz;
    int   k;
    rst = 1'b1; exc_pc = 0; req_ov = 0; req_sys = 0; req_brk = 0; req_ri = 0;
    int_pend = 0; eret = 0; mtc0_we = 0; mtc0_idx = 0; mtc0_data = 0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {58'h0, stall, flush, cp0_we, redir_valid, busy, 1'b0}, 64'h0);
    check("rst_data", {cp0_wdata, redir_pc}, 64'h0);
    rst = 1'b0;

    req(0, 1, 0, 0, 0, 6'h0, 32'h0000_0040);   // syscall, EXL=0
    do_eret();                                 // back to 0x40
    req(1, 0, 1, 0, 0, 6'h0, 32'h0000_0100);   // ov beats brk
    req(0, 0, 0, 1, 0, 6'h0, 32'h0000_0200);   // RI with EXL=1: no EPC write
    do_eret();                                 // EPC still 0x100
    mtc0(STAT_I, 32'h0000_0401);
    req(0, 0, 0, 0, 0, 6'b000001, 32'h0000_0300);
    do_eret();
    mtc0(STAT_I, 32'h0);
    req(0, 1, 0, 0, 1, 6'h0, 32'h0000_0140);   // exception beats eret
    do_eret();
    mtc0(EPC_I, 32'h0000_0500);
    do_eret();                                 // redirect to snooped EPC

    // Reset in the middle of the save sequence.
    @(negedge clk);
    req_sys = 1'b1; exc_pc = 32'h0000_0040;
    k = cyc;
    model(0, 1, 0, 0, 0, 6'h0, 32'h0000_0040, k, bz);
    @(negedge clk);
    req_sys = 1'b0; exc_pc = 32'h0;
    repeat (2) @(negedge clk);
    check("mid_cause_we", {56'h0, cp0_idx}, {56'h0, CAUSE_I});
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctrl", {59'h0, stall, flush, cp0_we, redir_valid, busy}, 64'h0);
    check("async_rst_data", {cp0_wdata, redir_pc}, 64'h0);
    sb.delete();
    st_m = 32'h0; epc_m = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    req(0, 1, 0, 0, 0, 6'h0, 32'h0000_0080);
    do_eret();

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
